// File: rtl/div_unit_pkg.sv
// Shared widths and state encoding for the radix-2 restoring divider.
package div_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned WORK_W = 2 * DATA_W + 1;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider, one quotient bit per clock.
// Result is {remainder, quotient}, held while start_i stays high.
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divider_i,
    input  logic              start_i,
    output logic [RES_W-1:0]  result_o,
    output logic              success_o
);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORK_W-1:0]   work_q;
    logic [WORK_W-1:0]   work_d;
    logic [DATA_W-1:0]   divisor_q;
    logic                neg_quo_q;
    logic                neg_rem_q;

    logic [DATA_W+1:0]   rem_sh;
    logic [DATA_W+1:0]   diff;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   dividend_abs;
    logic [DATA_W-1:0]   divisor_abs;

    // One restoring step plus capture-time magnitudes and final sign fix-up.
    always_comb begin
        rem_sh = work_q[WORK_W-1:DATA_W-1];
        diff   = rem_sh - {2'b00, divisor_q};
        // Shifted remainder is always below 2^33, so diff[33] marks a negative result.
        if (!diff[DATA_W+1]) begin
            work_d = {diff[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
        end else begin
            work_d = {rem_sh[DATA_W:0], work_q[DATA_W-2:0], 1'b0};
        end

        quo_fix = neg_quo_q ? (~work_d[DATA_W-1:0] + DATA_W'(1))
                            : work_d[DATA_W-1:0];
        rem_fix = neg_rem_q ? (~work_d[2*DATA_W-1:DATA_W] + DATA_W'(1))
                            : work_d[2*DATA_W-1:DATA_W];

        dividend_abs = (signed_i && dividend_i[DATA_W-1]) ? (~dividend_i + DATA_W'(1))
                                                          : dividend_i;
        divisor_abs  = (signed_i && divider_i[DATA_W-1])  ? (~divider_i + DATA_W'(1))
                                                          : divider_i;
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            success_o <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    result_o  <= '0;
                    success_o <= 1'b0;
                    if (start_i) begin
                        if (divider_i == '0) begin
                            state_q <= DIV_BYZERO;
                        end else begin
                            work_q    <= {(DATA_W + 1)'(0), dividend_abs};
                            divisor_q <= divisor_abs;
                            neg_quo_q <= signed_i & (dividend_i[DATA_W-1] ^ divider_i[DATA_W-1]);
                            neg_rem_q <= signed_i & dividend_i[DATA_W-1];
                            cnt_q     <= '0;
                            state_q   <= DIV_ON;
                        end
                    end
                end

                DIV_BYZERO: begin
                    if (!start_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        result_o  <= '0;
                        success_o <= 1'b1;
                        state_q   <= DIV_END;
                    end
                end

                DIV_ON: begin
                    if (!start_i) begin
                        // Abort: drop the partial result.
                        work_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= DIV_IDLE;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            result_o  <= {rem_fix, quo_fix};
                            success_o <= 1'b1;
                            state_q   <= DIV_END;
                        end
                    end
                end

                DIV_END: begin
                    if (!start_i) begin
                        result_o  <= '0;
                        success_o <= 1'b0;
                        state_q   <= DIV_IDLE;
                    end
                end

                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus per-cycle output compare.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divider_i;
    logic        start_i;
    logic [63:0] result_o;
    logic        success_o;

    int          checks;
    int          failures;
    int          cyc;
    logic        check_en;
    logic        exp_success;
    logic [63:0] exp_result;
    logic        lit_valid;
    logic [63:0] lit_val;
    string       tag;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divider_i  (divider_i),
        .start_i    (start_i),
        .result_o   (result_o),
        .success_o  (success_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero; x/0 gives 0.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Per-cycle compare against the expected outputs, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (success_o !== exp_success) begin
                failures++;
                $display("FAIL success [%s] cyc=%0d got=%b exp=%b", tag, cyc, success_o, exp_success);
            end
            checks++;
            if (result_o !== exp_result) begin
                failures++;
                $display("FAIL result [%s] cyc=%0d got=%h exp=%h", tag, cyc, result_o, exp_result);
            end
            if (lit_valid) begin
                checks++;
                if (result_o !== lit_val) begin
                    failures++;
                    $display("FAIL literal [%s] cyc=%0d got=%h exp=%h", tag, cyc, result_o, lit_val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; k counts edges from E0 (k=1). abort_at/rst_at of 0 mean none.
    task automatic do_div(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] lit,
                          input int abort_at, input int rst_at);
        int lat;
        lat        = (b == 32'd0) ? 2 : 33;
        tag        = name;
        signed_i   = s;
        dividend_i = a;
        divider_i  = b;
        start_i    = 1'b1;
        lit_val    = lit;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1) begin
                dividend_i = $urandom;
                divider_i  = $urandom;
                signed_i   = ~s;
            end
            if (k == abort_at) begin
                start_i = 1'b0;
                repeat (4) tick();
                return;
            end
            if (k == rst_at) begin
                rst     = 1'b1;
                start_i = 1'b0;
                tick();
                rst = 1'b0;
                repeat (3) tick();
                return;
            end
        end
        exp_success = 1'b1;
        exp_result  = model(s, a, b);
        lit_valid   = 1'b1;
        repeat (2) tick();
        start_i = 1'b0;
        tick();
        exp_success = 1'b0;
        exp_result  = 64'd0;
        lit_valid   = 1'b0;
        tick();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        check_en    = 1'b0;
        exp_success = 1'b0;
        exp_result  = 64'd0;
        lit_valid   = 1'b0;
        lit_val     = 64'd0;
        tag         = "reset";
        rst         = 1'b1;
        signed_i    = 1'b0;
        dividend_i  = 32'd0;
        divider_i   = 32'd0;
        start_i     = 1'b0;

        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        do_div("u100_7",      1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 0, 0);
        do_div("s-7_2",       1'b1, 32'hFFFFFFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 0, 0);
        do_div("s7_-2",       1'b1, 32'd7,         32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 0, 0);
        do_div("u_byzero",    1'b0, 32'h00001234,  32'd0,          64'h00000000_00000000, 0, 0);
        do_div("s_byzero",    1'b1, 32'h00001234,  32'd0,          64'h00000000_00000000, 0, 0);
        do_div("s_minovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 0, 0);
        do_div("u_max_1",     1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, 0, 0);
        do_div("u5_max",      1'b0, 32'd5,         32'hFFFFFFFF,   64'h00000005_00000000, 0, 0);
        do_div("abort",       1'b0, 32'd1000,      32'd3,          64'd0,                 10, 0);
        do_div("u9_3",        1'b0, 32'd9,         32'd3,          64'h00000000_00000003, 0, 0);
        do_div("rst_mid",     1'b1, 32'd12345,     32'd17,         64'd0,                 0, 20);
        do_div("s-100_7",     1'b1, 32'hFFFFFF9C,  32'd7,          64'hFFFFFFFE_FFFFFFF2, 0, 0);
        do_div("s-1000_-7",   1'b1, 32'hFFFFFC18,  32'hFFFFFFF9,   64'hFFFFFFFA_0000008E, 0, 0);

        repeat (2) tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Execute drives operands plus a level-held `start_i` and stalls the pipeline until `success_o` rises. The divider then presents `{remainder, quotient}` as the 64-bit HI/LO write value. Radix-2 restoring algorithm, one quotient bit per clock, signed and unsigned.

## Interface
- No parameters; width fixed at 32 (operands) / 64 (result).
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU
- `dividend_i`  in  32  dividend (rs)
- `divider_i`  in  32  divisor (rt)
- `start_i`  in  1  request; held high by execute until result consumed
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}` → `{HI, LO}`
- `success_o`  out  1  result valid; registered

## Operation
- States (2-bit, `defines.v`): `DIV_IDLE`, `DIV_BYZERO`, `DIV_ON`, `DIV_END`.
- DIV_IDLE: `success_o`=0, `result_o`=0. On `start_i`=1:
  - `divider_i`==0 → DIV_BYZERO.
  - else capture operands, set cnt=0 → DIV_ON.
  - Capture: `signed_i`=1 → absolute values of both operands, plus sign flags (quotient negative = sign(dividend) XOR sign(divisor); remainder negative = sign(dividend)). Unsigned → raw values, flags cleared.
- Datapath: 65-bit work register `{rem[32:0], quo[31:0]}`, initialised `{33'b0, |dividend|}`.
  - Per DIV_ON cycle: shift left 1; diff = rem[32:0] − {1'b0, |divisor|}.
  - diff ≥ 0 → rem = diff, quo[0] = 1; else quo[0] = 0.
  - cnt increments 0..31; at cnt==31 the step completes → DIV_END.
- Entry to DIV_END: `result_o` loaded with sign-corrected values.
  - Quotient negated (two's complement, 32-bit wrap) if its flag is set; remainder likewise.
  - `success_o` ← 1.
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0 (wrap; no trap).
- DIV_BYZERO: one cycle → DIV_END with `result_o`=64'b0, `success_o`=1. (Architecturally undefined; fixed here for determinism.)
- DIV_END: hold `result_o`/`success_o` while `start_i`=1. On `start_i`=0 → DIV_IDLE, clearing both outputs next edge.
- Abort: `start_i`=0 in DIV_ON or DIV_BYZERO → DIV_IDLE next edge. Partial result discarded, `success_o` never asserted.
- Operand inputs are ignored outside the DIV_IDLE capture edge. Changes mid-operation have no effect.

## Timing
- Reset (any state, including mid-division): state DIV_IDLE, `result_o`=0, `success_o`=0, cnt=0, work register 0.
- Edge E0 = first rising edge sampling `start_i`=1 in DIV_IDLE.
- Normal divide: iterations at E1..E32. `success_o` high in the cycle after E32 (33 clocks after E0).
- Divide by zero: `success_o` high after E1 (2 clocks after E0).
- Execute sees `success_o`=1 combinationally and drops `start_i` in the same cycle. The divider returns to IDLE at the next edge, so `success_o` is high for exactly one cycle in normal use.
- Back-to-back: a new `start_i`=1 can only be sampled from DIV_IDLE. Minimum one idle cycle between operations.

## Structure
- State encodings `DIV_IDLE`/`DIV_BYZERO`/`DIV_ON`/`DIV_END` go in `defines.v`, alongside the existing ALU/MEM opcode macros.
- Single module; no sub-module. The abs/negate helpers are inline expressions.
- Execute and the HI/LO write path consume `result_o` unchanged, with no reordering.

## Test plan
- Unsigned 100 / 7, `start_i` held → `success_o` at clock 33 after E0. `result_o` = {0x00000002, 0x0000000E}, held until `start_i` drops, then 0.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (0x1234 / 0, either signedness) → `success_o` at clock 2, `result_o`=0.
- Boundaries:
  - signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}
  - unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}
  - unsigned 5 / 0xFFFFFFFF → {5, 0}
- Abort and reset:
  - Drop `start_i` at clock 10 → IDLE, `success_o` never rises. A new start on 9 / 3 then yields {0, 3} after a full 33 clocks.
  - `rst` pulse at clock 20 of a divide → all outputs 0, next divide correct.
